// File: rtl/pc_select_unit.sv
// Next-PC selection: reset, trap, jump, branch, buffered redirect, stall hold, or PC+4.
// Optional macro PC_MISALIGN_CHECK_EN traps on targets whose bits [1:0] are non-zero.
module pc_select_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] jump_target_i,
  input  logic            trap_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            redirect_pending_o,
  output logic            misalign_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]      state;
  logic [0:0]      state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] pend;
  logic [XLEN-1:0] pend_nxt;
  logic            mis;
  logic            mis_nxt;
  logic            redirect;
  logic            tgt_bad;
  logic [XLEN-1:0] tgt_raw;
  logic [XLEN-1:0] tgt;

  // Jump outranks branch when both resolve in the same cycle.
  always_comb begin
    redirect = jump_i | branch_taken_i;
    tgt_raw  = jump_i ? jump_target_i : branch_target_i;
`ifdef PC_MISALIGN_CHECK_EN
    tgt      = tgt_raw;
    tgt_bad  = redirect & (tgt_raw[1:0] != 2'b00);
`else
    tgt      = tgt_raw & ~{{(XLEN-2){1'b0}}, 2'b11};
    tgt_bad  = 1'b0;
`endif
  end

  // Next-state selection in fixed priority order below reset.
  always_comb begin
    pc_nxt    = pc;
    state_nxt = state;
    pend_nxt  = pend;
    mis_nxt   = 1'b0;
    if (trap_i) begin
      pc_nxt    = TRAP_VECTOR;
      state_nxt = IDLE;
      pend_nxt  = '0;
    end else if (redirect) begin
      if (tgt_bad) begin
        // A bad target traps at once, even when it would have been buffered.
        pc_nxt    = TRAP_VECTOR;
        state_nxt = IDLE;
        pend_nxt  = '0;
        mis_nxt   = 1'b1;
      end else if (stall_i) begin
        pend_nxt  = tgt;
        state_nxt = HOLD;
      end else begin
        pc_nxt    = tgt;
        state_nxt = IDLE;
        pend_nxt  = '0;
      end
    end else if (state == HOLD) begin
      if (!stall_i) begin
        pc_nxt    = pend;
        state_nxt = IDLE;
        pend_nxt  = '0;
      end else begin
        pc_nxt    = pc;
      end
    end else if (!stall_i) begin
      pc_nxt = pc + XLEN'(4);
    end else begin
      pc_nxt = pc;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc    <= RESET_VECTOR;
      state <= IDLE;
      pend  <= '0;
      mis   <= 1'b0;
    end else begin
      pc    <= pc_nxt;
      state <= state_nxt;
      pend  <= pend_nxt;
      mis   <= mis_nxt;
    end
  end

  assign pc_o               = pc;
  assign pc_plus4_o         = pc + XLEN'(4);
  assign redirect_pending_o = (state == HOLD);
  assign misalign_o         = mis;

endmodule
